x_stream_source: RTL and testbench

Stream source for the perceptron input vector.
- Holds one `N_INPUTS`-word input vector (Q5.27 two's-complement) in a local buffer, loaded through a simple write port.
- On a `start` rising edge, emits `perc_start` and streams the vector in index order as an AXI-Stream master on `x_tdata`/`x_tvalid`/`x_tready`.
- Sits upstream of a perceptron (or a broadcast of perceptrons) and drives its stream slave and `start` inputs.

---
 rtl/x_stream_source_pkg.sv | 17 +
 rtl/x_stream_source_if.sv | 25 ++
 rtl/x_stream_source_ram.sv | 31 +++
 rtl/x_stream_source.sv | 213 +++++++++++++++++++++
 tb/tb_x_stream_source.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/x_stream_source_pkg.sv
// Shared perceptron constants: Q5.27 word format, input vector geometry and
// the stream source FSM encoding.
package perceptron_pkg;

  localparam int DATA_W   = 32;
  localparam int FRAC_W   = 27;
  localparam int N_INPUTS = 784;
  localparam int ADDR_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } src_state_t;

endpackage

// File: rtl/x_stream_source_if.sv
// AXI-Stream link carrying the input vector from the source to the perceptron.
interface x_stream_source_if #(
  parameter int DATA_W = perceptron_pkg::DATA_W
);

  logic [DATA_W-1:0] x_tdata;
  logic              x_tvalid;
  logic              x_tready;
  logic              x_tlast;

  modport master (
    output x_tdata,
    output x_tvalid,
    output x_tlast,
    input  x_tready
  );

  modport slave (
    input  x_tdata,
    input  x_tvalid,
    input  x_tlast,
    output x_tready
  );

endinterface

// File: rtl/x_stream_source_ram.sv
// Simple dual-port vector buffer: one write port, one synchronous read port
// with one cycle of latency. Contents deliberately survive reset.
module input_vector_ram #(
  parameter int DATA_W = perceptron_pkg::DATA_W,
  parameter int ADDR_W = perceptron_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // Memory write and registered read
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/x_stream_source.sv
// Streams the buffered perceptron input vector as an AXI-Stream frame on each
// start rise; a 2-entry skid behind the synchronous RAM keeps full rate.
module x_stream_source
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS = perceptron_pkg::N_INPUTS,
  parameter int DATA_W   = perceptron_pkg::DATA_W,
  parameter int ADDR_W   = perceptron_pkg::ADDR_W
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic                  load_valid,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_W-1:0]     load_data,
  output logic                  load_drop,
  input  logic                  start,
  output logic                  busy,
  output logic                  perc_start,
  output logic                  frame_done,
  x_stream_source_if.master     x_s
);

  localparam int                IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic [IDX_W-1:0]  END_IDX  = IDX_W'(N_INPUTS);

  src_state_t        r_state;
  logic              r_start_q;
  logic              r_busy;
  logic              r_perc_start;
  logic              r_frame_done;
  logic              r_load_drop;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_rd_pend;
  logic              r_pend_last;
  logic [DATA_W-1:0] r_skid_data [2];
  logic [1:0]        r_skid_last;
  logic [1:0]        r_skid_cnt;

  logic              w_start_rise;
  logic              w_hs;
  logic              w_out_free;
  logic              w_wr_en;
  logic              w_pop_skid;
  logic              w_ram_to_out;
  logic              w_ram_to_skid;
  logic              w_push_slot;
  logic [1:0]        w_skid_cnt_nxt;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  input_vector_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (s_axi_aclk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (load_addr),
    .i_wr_data (load_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Edge detect, handshake and load acceptance
  always_comb begin
    w_start_rise = start & ~r_start_q;
    w_hs         = r_tvalid & x_s.x_tready;
    w_out_free   = ~r_tvalid | w_hs;
    w_wr_en      = load_valid & (r_state == ST_IDLE) & ({1'b0, load_addr} < END_IDX);
  end

  // Route RAM data and skid entries into the output register
  always_comb begin
    w_pop_skid    = 1'b0;
    w_ram_to_out  = 1'b0;
    w_ram_to_skid = 1'b0;
    if (r_state == ST_STREAM) begin
      if (w_hs && r_tlast) begin
        w_pop_skid    = 1'b0;
        w_ram_to_out  = 1'b0;
        w_ram_to_skid = 1'b0;
      end else if (w_out_free) begin
        w_pop_skid    = (r_skid_cnt != 2'd0);
        w_ram_to_out  = r_rd_pend & (r_skid_cnt == 2'd0);
        w_ram_to_skid = r_rd_pend & (r_skid_cnt != 2'd0);
      end else begin
        w_ram_to_skid = r_rd_pend;
      end
    end else begin
      w_pop_skid    = 1'b0;
      w_ram_to_out  = 1'b0;
      w_ram_to_skid = 1'b0;
    end
    w_skid_cnt_nxt = r_skid_cnt - {1'b0, w_pop_skid} + {1'b0, w_ram_to_skid};
    w_push_slot    = (r_skid_cnt == 2'd2) | ((r_skid_cnt == 2'd1) & ~w_pop_skid);
  end

  // Prefetch: only issue a read when the skid can absorb it under a full stall
  always_comb begin
    w_rd_addr = r_rd_idx[ADDR_W-1:0];
    case (r_state)
      ST_IDLE:   w_rd_en = w_start_rise;
      ST_PRIME:  w_rd_en = (r_rd_idx < END_IDX);
      ST_STREAM: w_rd_en = (r_rd_idx < END_IDX) & (w_skid_cnt_nxt < 2'd2);
      default:   w_rd_en = 1'b0;
    endcase
  end

  // Frame FSM, output register, read pipeline and skid buffer
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state        <= ST_IDLE;
      r_start_q      <= 1'b0;
      r_busy         <= 1'b0;
      r_perc_start   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_load_drop    <= 1'b0;
      r_tdata        <= {DATA_W{1'b0}};
      r_tvalid       <= 1'b0;
      r_tlast        <= 1'b0;
      r_rd_idx       <= {IDX_W{1'b0}};
      r_rd_pend      <= 1'b0;
      r_pend_last    <= 1'b0;
      r_skid_data[0] <= {DATA_W{1'b0}};
      r_skid_data[1] <= {DATA_W{1'b0}};
      r_skid_last    <= 2'b00;
      r_skid_cnt     <= 2'd0;
    end else begin
      r_start_q   <= start;
      r_load_drop <= load_valid & ~w_wr_en;
      r_rd_pend   <= w_rd_en;
      r_pend_last <= w_rd_en & (r_rd_idx == LAST_IDX);
      r_skid_cnt  <= w_skid_cnt_nxt;
      if (w_rd_en) begin
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      end
      if (w_pop_skid) begin
        r_skid_data[0] <= r_skid_data[1];
        r_skid_last[0] <= r_skid_last[1];
      end
      // Push after pop so a simultaneous refill lands in the freed slot
      if (w_ram_to_skid) begin
        r_skid_data[w_push_slot] <= w_rd_data;
        r_skid_last[w_push_slot] <= r_pend_last;
      end

      case (r_state)
        ST_IDLE: begin
          r_frame_done <= 1'b0;
          r_tvalid     <= 1'b0;
          r_tlast      <= 1'b0;
          if (w_start_rise) begin
            r_state      <= ST_PRIME;
            r_busy       <= 1'b1;
            r_perc_start <= 1'b1;
          end
        end
        ST_PRIME: begin
          r_tdata  <= w_rd_data;
          r_tlast  <= r_pend_last;
          r_tvalid <= 1'b1;
          r_state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_hs && r_tlast) begin
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_perc_start <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= ST_DONE;
          end else if (w_pop_skid) begin
            r_tdata  <= r_skid_data[0];
            r_tlast  <= r_skid_last[0];
            r_tvalid <= 1'b1;
          end else if (w_ram_to_out) begin
            r_tdata  <= w_rd_data;
            r_tlast  <= r_pend_last;
            r_tvalid <= 1'b1;
          end else if (w_hs) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_rd_idx     <= {IDX_W{1'b0}};
          r_state      <= ST_IDLE;
        end
        default: begin
          r_busy       <= 1'b0;
          r_perc_start <= 1'b0;
          r_tvalid     <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign load_drop    = r_load_drop;
  assign busy         = r_busy;
  assign perc_start   = r_perc_start;
  assign frame_done   = r_frame_done;
  assign x_s.x_tdata  = r_tdata;
  assign x_s.x_tvalid = r_tvalid;
  assign x_s.x_tlast  = r_tlast;

endmodule

// File: tb/tb_x_stream_source.sv
// Scoreboard bench for x_stream_source: a vector model predicts each frame's
// beats; a negedge monitor checks beats, stall stability and frame_done timing.
module tb_x_stream_source;

  localparam int N  = 784;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_drop;
  logic          start;
  logic          busy;
  logic          perc_start;
  logic          frame_done;

  x_stream_source_if #(.DATA_W(DW)) xs ();

  x_stream_source #(.N_INPUTS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .load_valid   (load_valid),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_drop    (load_drop),
    .start        (start),
    .busy         (busy),
    .perc_start   (perc_start),
    .frame_done   (frame_done),
    .x_s          (xs)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          t_start = 0;
  int          hs_frame = 0;
  int          first_hs_rel = 0;
  int          last_hs_rel = 0;
  int          last_hs_cyc = 0;
  int          done_rel = 0;
  int          done_cnt = 0;
  bit          frame_active = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [DW-1:0] mem_model [N];
  logic [DW:0]   sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ready driver: always 1 or a fair coin per cycle
  initial begin
    xs.x_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      xs.x_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: scoreboard pop on handshake, stall stability, frame_done spacing
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", xs.x_tvalid, 1'b1);
          chk("stall_data", xs.x_tdata, prev_data);
          chk("stall_last", xs.x_tlast, prev_last);
        end
        if (xs.x_tvalid && xs.x_tready) begin
          chk("beat_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("beat_data", xs.x_tdata, e[DW-1:0]);
            chk("beat_last", xs.x_tlast, e[DW]);
          end
          hs_frame++;
          last_hs_cyc = cyc;
          last_hs_rel = cyc - t_start;
          if (hs_frame == 1) first_hs_rel = cyc - t_start;
        end
        prev_stall = xs.x_tvalid && !xs.x_tready;
        prev_data  = xs.x_tdata;
        prev_last  = xs.x_tlast;
        if (frame_done) begin
          done_cnt++;
          done_rel = cyc - t_start;
          chk("done_after_last_hs", cyc - last_hs_cyc, 1);
          frame_active = 1'b0;
        end
      end
    end
  end

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit exp_drop;
    exp_drop = frame_active || (int'(a) >= N);
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    chk("load_drop", load_drop, exp_drop);
    if (!exp_drop) mem_model[a] = d;
  endtask

  task automatic do_start(input bit expect_frame);
    @(posedge clk);
    #1;
    start = 1'b1;
    if (expect_frame) begin
      t_start      = cyc;
      hs_frame     = 0;
      frame_active = 1'b1;
      for (int i = 0; i < N; i++) sb.push_back({(i == N - 1), mem_model[i]});
    end
    @(posedge clk);
    @(negedge clk);
    if (expect_frame) begin
      chk("busy_cycle1", busy, 1'b1);
      chk("perc_start_cycle1", perc_start, 1'b1);
      chk("tvalid_cycle1", xs.x_tvalid, 1'b0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("frame_done_seen", done_cnt, prev + 1);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (hs_frame < target && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_beat", hs_frame, target);
  endtask

  task automatic full_rate_frame();
    int prev;
    rand_rdy = 1'b0;
    prev = done_cnt;
    do_start(1'b1);
    wait_done(prev);
    chk("first_beat_cycle", first_hs_rel, 2);
    chk("last_beat_cycle", last_hs_rel, N + 1);
    chk("frame_done_cycle", done_rel, N + 2);
    chk("beat_count", hs_frame, N);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    start      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", xs.x_tvalid, 1'b0);
    chk("rst_tlast", xs.x_tlast, 1'b0);
    chk("rst_tdata", xs.x_tdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_perc_start", perc_start, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_load_drop", load_drop, 1'b0);
    rst = 1'b0;

    // ramp vector i * 2^27, full-rate frame with exact cycle timing
    for (int i = 0; i < N; i++) do_load(AW'(i), DW'(i) << 27);
    full_rate_frame();

    // random vector under random backpressure, with a write and start mid-frame
    for (int i = 0; i < N; i++) do_load(AW'(i), $urandom);
    rand_rdy = 1'b1;
    prev = done_cnt;
    do_start(1'b1);
    wait_beats(100);
    do_load(AW'(5), 32'hDEAD_BEEF);
    do_start(1'b0);
    wait_done(prev);
    repeat (6) @(posedge clk);
    #1;
    chk("single_frame", done_cnt, prev + 1);
    chk("busy_idle", busy, 1'b0);

    // out-of-range writes are dropped, in-range IDLE write lands
    do_load(AW'(784), 32'h1234_5678);
    do_load(AW'(1023), 32'h8765_4321);
    do_load(AW'(7), $urandom);
    full_rate_frame();

    // reset mid-frame at beat 400, then a clean frame from beat 0
    rand_rdy = 1'b1;
    prev = done_cnt;
    do_start(1'b1);
    wait_beats(400);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", xs.x_tvalid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_perc_start", perc_start, 1'b0);
    sb.delete();
    frame_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("no_done_after_reset", done_cnt, prev);
    do_start(1'b1);
    wait_done(prev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
